dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 30 +++
 rtl/dmem_responder.sv | 97 +++++++++
 tb/tb_dmem_responder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: load/store encodings, RAM window and responder FSM types
package dmem_responder_pkg;
    typedef enum logic [2:0] {
        MEM_READ_NONE   = 3'd0,
        MEM_READ_BYTE   = 3'd1,
        MEM_READ_HALF   = 3'd2,
        MEM_READ_WORD   = 3'd3,
        MEM_READ_BYTE_U = 3'd4,
        MEM_READ_HALF_U = 3'd5
    } mem_read_t;
    typedef enum logic [1:0] {
        MEM_WRITE_NONE = 2'd0,
        MEM_WRITE_BYTE = 2'd1,
        MEM_WRITE_HALF = 2'd2,
        MEM_WRITE_WORD = 2'd3
    } mem_write_t;
    typedef enum logic [1:0] {DMEM_IDLE, DMEM_BUSY, DMEM_RESP} dmem_state_t;
    localparam logic [31:0] BAD_VAL       = 32'hDEAD_BEEF;
    localparam logic [31:0] RAM_BASE_ADDR = 32'h0000_1000;
    localparam int          RAM_BITS      = 13;
    localparam int          DMEM_WAIT_MAX = 15;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane enables/replicated store data and load extract with sign/zero extension
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  read,
    input  logic [1:0]  write,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        be    = write == MEM_WRITE_BYTE ? 4'b0001 << addr_lo :
                write == MEM_WRITE_HALF ? 4'b0011 << {addr_lo[1], 1'b0} :
                write == MEM_WRITE_WORD ? 4'hf : 4'h0;
        wword = write == MEM_WRITE_BYTE ? {4{wdata[7:0]}} :
                write == MEM_WRITE_HALF ? {2{wdata[15:0]}} : wdata;
        b     = 8'(rword >> {addr_lo, 3'b000});
        h     = 16'(rword >> {addr_lo[1], 4'b0000});
        rdata = read == MEM_READ_BYTE   ? {{24{b[7]}}, b} :
                read == MEM_READ_HALF   ? {{16{h[15]}}, h} :
                read == MEM_READ_WORD   ? rword :
                read == MEM_READ_BYTE_U ? {24'h0, b} :
                read == MEM_READ_HALF_U ? {16'h0, h} : 32'h0;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with wait states; DMEM_ERR_RSP_EN enables rsp_err and fault_cnt
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int    WAIT_CYCLES = 0,
    parameter int    RAM_AW      = RAM_BITS,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_read,
    input  logic [1:0]  req_write,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         DEPTH     = 2 ** (RAM_AW - 2);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > DMEM_WAIT_MAX ? DMEM_WAIT_MAX : WAIT_CYCLES);
    dmem_state_t state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] addr_q, wdata_q, off, rword, wword, ext, rdata_q;
    logic [2:0]  read_q;
    logic [1:0]  write_q;
    logic [3:0]  be;
    logic        fault, commit, half, word;
    logic [31:0] mem [DEPTH];
    assign off   = addr_q - RAM_BASE_ADDR;
    assign rword = mem[off[RAM_AW-1:2]];
    dmem_lane_align u_align (
        .addr_lo(addr_q[1:0]),
        .read   (read_q),
        .write  (write_q),
        .wdata  (wdata_q),
        .rword  (rword),
        .be     (be),
        .wword  (wword),
        .rdata  (ext)
    );
    always_comb begin
        half      = read_q == MEM_READ_HALF || read_q == MEM_READ_HALF_U || write_q == MEM_WRITE_HALF;
        word      = read_q == MEM_READ_WORD || write_q == MEM_WRITE_WORD;
        fault     = (off >> RAM_AW) != 0 || (half && addr_q[0]) || (word && addr_q[1:0] != 2'b00) ||
                    (read_q != MEM_READ_NONE && write_q != MEM_WRITE_NONE) || read_q > MEM_READ_HALF_U;
        commit    = state == DMEM_BUSY && cnt == 4'd0;
        req_ready = state == DMEM_IDLE;
        rsp_valid = state == DMEM_RESP;
        state_nx  = state == DMEM_IDLE ? (req_valid ? DMEM_BUSY : DMEM_IDLE) :
                    state == DMEM_BUSY ? (commit ? DMEM_RESP : DMEM_BUSY) :
                    (rsp_ready ? DMEM_IDLE : DMEM_RESP);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DMEM_IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'h0;
        end else begin
            state <= state_nx;
            if (state == DMEM_IDLE && req_valid) begin
                addr_q  <= req_addr;
                read_q  <= req_read;
                write_q <= req_write;
                wdata_q <= req_wdata;
                cnt     <= WAIT_INIT;
            end
            if (state == DMEM_BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (commit) rdata_q <= fault ? BAD_VAL : ext;
        end
    end
    // RAM is not reset; a reset landing on the commit edge still blocks the store
    always_ff @(posedge clk) begin
        if (commit && !fault && !rst)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[off[RAM_AW-1:2]][8*i +: 8] <= wword[8*i +: 8];
    end
    assign rsp_rdata = rdata_q;
`ifdef DMEM_ERR_RSP_EN
    logic        err_q;
    logic [15:0] fault_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            fault_cnt <= 16'h0;
        end else if (commit) begin
            err_q <= fault;
            if (fault && fault_cnt != 16'hffff) fault_cnt <= fault_cnt + 16'h1;
        end
    end
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store/fault/handshake vectors for dmem_responder with WAIT_CYCLES=2
module tb_dmem_responder;
    import dmem_responder_pkg::*;
    localparam int W   = 2;
    localparam int LAT = 2 + W;
`ifdef DMEM_ERR_RSP_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0, rsp_rdata;
    logic [2:0]  req_read = 3'd0;
    logic [1:0]  req_write = 2'd0;
    int          n_vec = 0, n_err = 0;
    dmem_responder #(.WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_read (req_read),
        .req_write(req_write),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr, input logic [31:0] wd);
        int t = 0;
        while (!req_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        req_valid = 1'b1;
        req_read  = rd;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask
    task automatic get(input bit ack, output logic [31:0] d, output logic e, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        d = rsp_rdata;
        e = rsp_err;
        if (ack) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask
    task automatic do_op(input string tag, input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_d, input logic is_fault);
        logic [31:0] d;
        logic        e;
        int          lat;
        send(rd, wr, addr, wd);
        get(1'b1, d, e, lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_err"}, {31'h0, e}, {31'h0, is_fault & ERR_EN});
    endtask
    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'h0, rsp_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        do_op("sw1000", MEM_READ_NONE, MEM_WRITE_WORD, 32'h1000, 32'hDEADBEEF, 32'h0, 1'b0);
        do_op("lw1000", MEM_READ_WORD, MEM_WRITE_NONE, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0);
        do_op("sw1004", MEM_READ_NONE, MEM_WRITE_WORD, 32'h1004, 32'h11223344, 32'h0, 1'b0);
        do_op("sb1005", MEM_READ_NONE, MEM_WRITE_BYTE, 32'h1005, 32'h00000080, 32'h0, 1'b0);
        do_op("lb1005", MEM_READ_BYTE, MEM_WRITE_NONE, 32'h1005, 32'h0, 32'hFFFFFF80, 1'b0);
        do_op("lbu1005", MEM_READ_BYTE_U, MEM_WRITE_NONE, 32'h1005, 32'h0, 32'h00000080, 1'b0);
        do_op("lw1004a", MEM_READ_WORD, MEM_WRITE_NONE, 32'h1004, 32'h0, 32'h11228044, 1'b0);
        do_op("sh1006", MEM_READ_NONE, MEM_WRITE_HALF, 32'h1006, 32'h0000F00D, 32'h0, 1'b0);
        do_op("lh1006", MEM_READ_HALF, MEM_WRITE_NONE, 32'h1006, 32'h0, 32'hFFFFF00D, 1'b0);
        do_op("lhu1006", MEM_READ_HALF_U, MEM_WRITE_NONE, 32'h1006, 32'h0, 32'h0000F00D, 1'b0);
        do_op("lh1004", MEM_READ_HALF, MEM_WRITE_NONE, 32'h1004, 32'h0, 32'hFFFF8044, 1'b0);
        do_op("lw1004b", MEM_READ_WORD, MEM_WRITE_NONE, 32'h1004, 32'h0, 32'hF00D8044, 1'b0);
        do_op("sw2ffc", MEM_READ_NONE, MEM_WRITE_WORD, 32'h2FFC, 32'hCAFEF00D, 32'h0, 1'b0);
        do_op("lw2ffc", MEM_READ_WORD, MEM_WRITE_NONE, 32'h2FFC, 32'h0, 32'hCAFEF00D, 1'b0);
        do_op("noop", MEM_READ_NONE, MEM_WRITE_NONE, 32'h1000, 32'h0, 32'h0, 1'b0);
        do_op("lw1002", MEM_READ_WORD, MEM_WRITE_NONE, 32'h1002, 32'h0, BAD_VAL, 1'b1);
        do_op("sw3000", MEM_READ_NONE, MEM_WRITE_WORD, 32'h3000, 32'h55555555, BAD_VAL, 1'b1);
`ifdef DMEM_ERR_RSP_EN
        check("fault_cnt2", {16'h0, dut.fault_cnt}, 32'd2);
`endif
        do_op("sh1001", MEM_READ_NONE, MEM_WRITE_HALF, 32'h1001, 32'h0000AAAA, BAD_VAL, 1'b1);
        do_op("lw0ffc", MEM_READ_WORD, MEM_WRITE_NONE, 32'h0FFC, 32'h0, BAD_VAL, 1'b1);
        do_op("rdwr", MEM_READ_WORD, MEM_WRITE_WORD, 32'h1000, 32'h0, BAD_VAL, 1'b1);
        do_op("rd110", 3'b110, MEM_WRITE_NONE, 32'h1000, 32'h0, BAD_VAL, 1'b1);
`ifdef DMEM_ERR_RSP_EN
        check("fault_cnt6", {16'h0, dut.fault_cnt}, 32'd6);
`endif
        do_op("lw1000u", MEM_READ_WORD, MEM_WRITE_NONE, 32'h1000, 32'h0, 32'hDEADBEEF, 1'b0);
        send(MEM_READ_WORD, MEM_WRITE_NONE, 32'h1004, 32'h0);
        get(1'b0, d, e, lat);
        check("hold_lat", lat, LAT);
        req_valid = 1'b1;
        req_read  = MEM_READ_WORD;
        req_addr  = 32'h1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", {31'h0, rsp_valid}, 32'h1);
            check("hold_data", rsp_rdata, 32'hF00D8044);
            check("hold_req_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("post_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        do_op("sw1010", MEM_READ_NONE, MEM_WRITE_WORD, 32'h1010, 32'hAAAA5555, 32'h0, 1'b0);
        send(MEM_READ_NONE, MEM_WRITE_WORD, 32'h1010, 32'h12345678);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("mid_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("mid_rst_rdata", rsp_rdata, 32'h0);
        check("mid_rst_err", {31'h0, rsp_err}, 32'h0);
`ifdef DMEM_ERR_RSP_EN
        check("mid_rst_fault_cnt", {16'h0, dut.fault_cnt}, 32'd0);
`endif
        do_op("lw1010", MEM_READ_WORD, MEM_WRITE_NONE, 32'h1010, 32'h0, 32'hAAAA5555, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
